// File: rtl/coef_loader_pkg.sv
// Shared definitions for the 21-tap symmetric FIR filter and its coefficient loader.
// The filter and the loader both take their geometry from here.
package coef_loader_pkg;

  localparam int FIR_NTAP = 21;
  localparam int FIR_CW   = 16;
  localparam int FIR_IW   = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MIRROR,
    FIN
  } state_t;

endpackage

// File: rtl/coef_loader.sv
// Coefficient loader: takes coefficients from a valid/ready stream and writes them to the
// filter's tap write port. In symmetric mode it takes only the first half and writes the mirror itself.
module coef_loader
  import coef_loader_pkg::*;
#(
  parameter int NTAP = FIR_NTAP,
  parameter int CW   = FIR_CW,
  parameter int IW   = FIR_IW
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          cfg_start,
  input  logic          cfg_sym,
  input  logic          cfg_abort,
  input  logic          c_valid,
  output logic          c_ready,
  input  logic [CW-1:0] c_data,
  output logic          h_write,
  output logic [IW-1:0] h_idx,
  output logic [CW-1:0] h_data,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int HALF = (NTAP + 1) / 2;
  localparam int SW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NTAP - 1);
  localparam logic [IW-1:0] HALF_IDX = IW'(HALF - 1);

  if (((NTAP % 2) == 0) || (NTAP > (1 << IW))) begin : g_param_check
    $error("coef_loader: NTAP must be odd and fit in IW index bits");
  end

  state_t        state;
  state_t        state_next;
  logic          sym;
  logic [IW-1:0] cnt;
  logic [CW-1:0] shadow [HALF];
  logic          accept;
  logic          last_load;
  logic          last_mirror;
  logic [SW-1:0] mirror_sel;

  assign accept      = c_valid & c_ready;
  assign last_load   = accept & (cnt == (sym ? HALF_IDX : LAST_IDX));
  assign last_mirror = (cnt == LAST_IDX);
  // Tap j of the mirrored half reuses shadow entry NTAP-1-j.
  assign mirror_sel  = SW'(LAST_IDX - cnt);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_next;
  end

  // NOTE: next-state takes a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cfg_start) state_next = LOAD;
      LOAD: begin
        if (cfg_abort)      state_next = IDLE;
        else if (last_load) state_next = sym ? MIRROR : FIN;
      end
      MIRROR: begin
        if (cfg_abort)        state_next = IDLE;
        else if (last_mirror) state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    c_ready = (state == LOAD);
    busy    = (state != IDLE);
  end

  // Write port, counter, done pulse and sticky error. Abort takes priority over any write that cycle.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sym     <= 1'b0;
      cnt     <= '0;
      h_write <= 1'b0;
      h_idx   <= '0;
      h_data  <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      h_write <= 1'b0;
      done    <= (state == FIN);
      case (state)
        IDLE: begin
          if (cfg_start) begin
            sym <= cfg_sym;
            cnt <= '0;
            err <= 1'b0;
          end
        end
        LOAD: begin
          if (cfg_abort) begin
            err <= 1'b1;
          end else begin
            if (cfg_start) err <= 1'b1;
            if (accept) begin
              h_write <= 1'b1;
              h_idx   <= cnt;
              h_data  <= c_data;
              cnt     <= cnt + IW'(1);
            end
          end
        end
        MIRROR: begin
          if (cfg_abort) begin
            err <= 1'b1;
          end else begin
            if (cfg_start) err <= 1'b1;
            h_write <= 1'b1;
            h_idx   <= cnt;
            h_data  <= shadow[mirror_sel];
            cnt     <= cnt + IW'(1);
          end
        end
        FIN: begin
          if (cfg_start) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the shadow file is cleared on reset so a reset never leaves stale taps to mirror.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < HALF; i++) shadow[i] <= '0;
    end else if ((state == LOAD) && accept && sym && !cfg_abort) begin
      shadow[cnt[SW-1:0]] <= c_data;
    end
  end

endmodule

// File: doc/coef_loader.md
Name: coef_loader

Overview:
- Upstream configuration stage for the 21-tap symmetric FIR filter block.
- Accepts a stream of 16-bit signed coefficients over a valid/ready handshake.
- Sequences them onto the filter's coefficient write port (`h_write`/`h_idx`/`h_data`), one tap per cycle.
- Symmetric mode: accepts only the first (NTAP+1)/2 coefficients and generates the mirrored half internally.

Parameters:
- NTAP, 21: number of filter taps; must be odd, checked at elaboration.
- CW, 16: coefficient width, two's complement.
- IW, 5: tap index width; 2^IW >= NTAP.

Ports:
- `clk`  in  1  clock
- `n_reset`  in  1  asynchronous, active-low reset
- `cfg_start`  in  1  pulse; begins a load sequence
- `cfg_sym`  in  1  sampled with `cfg_start`; 1 = symmetric (half) load
- `cfg_abort`  in  1  terminates an active sequence
- `c_valid`  in  1  coefficient word valid
- `c_ready`  out  1  loader accepts word this cycle
- `c_data`  in  CW  coefficient word, signed
- `h_write`  out  1  coefficient write strobe to filter
- `h_idx`  out  IW  tap index
- `h_data`  out  CW  coefficient value
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle pulse on successful completion
- `err`  out  1  sticky error flag; cleared by next accepted `cfg_start`

Behaviour:
- Reset: all outputs 0 (`c_ready`, `h_write`, `h_idx`, `h_data`, `busy`, `done`, `err`). FSM goes to IDLE, counters and shadow registers clear. Reset mid-sequence abandons it; no further writes are issued.
- FSM states: IDLE, LOAD, MIRROR, FIN.
- IDLE:
  - `cfg_start`=1: latch `cfg_sym`, clear `err` and the index counter, go to LOAD.
  - `c_valid` is ignored; `c_ready`=0.
- LOAD:
  - `c_ready`=1 combinationally from state.
  - Accept = `c_valid` & `c_ready`. On accept at count k: next cycle `h_write`=1, `h_idx`=k, `h_data`=`c_data`. In symmetric mode the word is also stored in `shadow[k]`.
  - Exit after the last accept. Full mode: k=NTAP-1, go to FIN. Symmetric mode: k=(NTAP-1)/2, go to MIRROR.
  - Gaps in `c_valid` stall the sequence with no write and no timeout.
- MIRROR:
  - One write per cycle for j=(NTAP+1)/2 .. NTAP-1, with `h_data`=`shadow[NTAP-1-j]`, registered like LOAD writes. For NTAP=21: idx 11..20 take shadow 9..0.
  - `c_ready`=0. After j=NTAP-1, go to FIN.
- FIN: `done`=1 for exactly one cycle, then IDLE.
- `busy`=1 in LOAD, MIRROR and FIN.
- Outputs `h_write`/`h_idx`/`h_data` are registered. `h_write` is 0 on every non-write cycle; `h_idx`/`h_data` hold their last value.
- Latency with a gapless stream, `cfg_start` sampled at edge t0:
  - Full mode: accepts t1..t21, writes t2..t22, `done` at t23.
  - Symmetric mode: accepts t1..t11, writes t2..t22, `done` at t23.
- `cfg_start` while `busy`: ignored, sets `err`, sequence continues unaffected.
- `cfg_abort` in LOAD/MIRROR:
  - Go to IDLE next cycle and set `err`; no `done`.
  - A write already registered in the abort cycle still appears. Taps already written remain in the filter.
  - `cfg_abort` in IDLE has no effect.
- Simultaneous `cfg_abort` and `cfg_start` in IDLE: start wins. In LOAD/MIRROR: abort wins and `err` is set.
- Simultaneous `cfg_start` and reset: reset wins.
- Data is passed bit-exact; no saturation or scaling.

Decomposition:
- Shared package: `FIR_NTAP`=21, `FIR_CW`=16, `FIR_IW`=5, and the FSM state enum (IDLE/LOAD/MIRROR/FIN). The filter and loader both reference these.
- No sub-module: the shadow register file (NTAP+1)/2 x CW stays inline.

Test Plan:
- Full load: start with `cfg_sym`=0, gapless stream 1..21 -> 21 writes, idx 0..20 with data 1..21, at t2..t22; `done` at t23; `err`=0.
- Symmetric load: `cfg_sym`=1, stream -10,62,84,-296,-246,954,477,-2645,-689,10122,17159 -> writes idx 0..10 with these values, then idx 11..20 with 10122,-689,-2645,477,954,-246,-296,84,62,-10; `c_ready`=0 after 11 accepts; `done` at t23.
- Backpressure gaps: `c_valid` toggles 1,0,1,0 through a full load -> exactly 21 writes, indices contiguous and ascending, `done` once.
- Abort: `cfg_abort` after 5 accepts -> writes idx 0..4 only, `busy` drops next cycle, `err`=1, no `done`. A following `cfg_start` clears `err`.
- Start while busy: `cfg_start` pulsed mid-LOAD -> `err`=1; sequence still completes 21 writes and `done`.
- Reset mid-MIRROR: `n_reset` low at idx 14 -> all outputs 0 immediately, no writes after reset release until a new `cfg_start`.
